// File: rtl/dm_arbiter_if.sv
// Signal bundle between the two requesters, dm_arbiter and the data memory.
// The slave side is the arbiter. The master side is the requesters plus the memory.
interface dm_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [2:0]  p0_op;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [2:0]  p1_op;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic [31:0] m_A;
  logic [31:0] m_WD;
  logic [2:0]  m_op;
  logic        m_WE;
  logic [31:0] m_rdata;

  modport master (
    output p0_req, p0_we, p0_op, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_op, p1_addr, p1_wdata,
    output m_rdata,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  m_A, m_WD, m_op, m_WE
  );

  modport slave (
    input  p0_req, p0_we, p0_op, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_op, p1_addr, p1_wdata,
    input  m_rdata,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output m_A, m_WD, m_op, m_WE
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory: one access at a time,
// IDLE -> ACCESS -> RESP. Misaligned or unknown ops are rejected before they reach memory.
module dm_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        grant, grant_p1;
  logic        sel_we, sel_err;
  logic [2:0]  sel_op;
  logic [31:0] sel_addr, sel_wdata;

  logic        owner_q, we_q, err_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  starve_cnt;

  logic        p0_ack_q, p1_ack_q, p0_err_q, p1_err_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;
  logic [31:0] load_data;

  function automatic logic access_err(input logic [2:0] op, input logic [1:0] low);
    case (op)
      DM_W:        return low != 2'b00;
      DM_H, DM_HU: return low[0];
      DM_B, DM_BU: return 1'b0;
      default:     return 1'b1;
    endcase
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_p1  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          grant     = 1'b1;
          grant_p1  = !bus.p0_req || (starve_cnt == LIMIT);
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_we    = grant_p1 ? bus.p1_we    : bus.p0_we;
  assign sel_op    = grant_p1 ? bus.p1_op    : bus.p0_op;
  assign sel_addr  = grant_p1 ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant_p1 ? bus.p1_wdata : bus.p0_wdata;
  assign sel_err   = access_err(sel_op, sel_addr[1:0]);

  // Stores and rejected accesses return zero rather than whatever the memory drives.
  assign load_data = (we_q || err_q) ? '0 : bus.m_rdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      op_q       <= DM_W;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_q <= grant_p1;
        we_q    <= sel_we;
        err_q   <= sel_err;
        op_q    <= sel_op;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        // Only a port-0 win over a waiting port 1 counts towards starvation.
        if (grant_p1 || !bus.p1_req) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
      p0_ack_q   <= (state == ACCESS) && !owner_q;
      p1_ack_q   <= (state == ACCESS) &&  owner_q;
      p0_err_q   <= (state == ACCESS) && !owner_q && err_q;
      p1_err_q   <= (state == ACCESS) &&  owner_q && err_q;
      p0_rdata_q <= ((state == ACCESS) && !owner_q) ? load_data : '0;
      p1_rdata_q <= ((state == ACCESS) &&  owner_q) ? load_data : '0;
    end
  end

  assign bus.m_A      = addr_q;
  assign bus.m_WD     = wdata_q;
  assign bus.m_op     = op_q;
  assign bus.m_WE     = (state == ACCESS) && we_q && !err_q && !reset;
  assign bus.p0_ack   = p0_ack_q;
  assign bus.p1_ack   = p1_ack_q;
  assign bus.p0_err   = p0_err_q;
  assign bus.p1_err   = p1_err_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: byte-array memory, two requester agents,
// and a transaction-level reference model compared against the DUT every cycle.
module tb_dm_arbiter;
  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  dm_arbiter_if bus ();
  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mem    [256];
  logic [7:0] shadow [256];

  req_t q0[$], q1[$];
  int   gap_pct = 0;
  logic seen0 = 1'b0, seen1 = 1'b0;
  logic last_err0 = 1'b0, last_err1 = 1'b0;
  logic [31:0] last_rd0 = '0, last_rd1 = '0;
  int lat0 = 0, lat1 = 0, t0 = 0, t1 = 0;
  int n_ack0 = 0, n_ack1 = 0, we_cnt = 0, wait0 = 0, wait1 = 0;
  int ack_log[$], grant_log[$];

  // Reference model state: phase 0 free, 1 memory cycle, 2 response cycle.
  int          phase = 0;
  int          starve = 0;
  logic        mdl_owner = 1'b0, mdl_we = 1'b0, mdl_err = 1'b0;
  logic [2:0]  mdl_op = DM_W;
  logic [31:0] mdl_addr = '0, mdl_wd = '0;
  logic        exp_ack [2] = '{1'b0, 1'b0};
  logic        exp_err [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rd  [2] = '{32'd0, 32'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    if (op == DM_W) return 4;
    if (op == DM_H || op == DM_HU) return 2;
    return 1;
  endfunction

  function automatic logic is_bad(input logic [2:0] op, input logic [31:0] addr);
    if (!(op inside {DM_W, DM_H, DM_HU, DM_B, DM_BU})) return 1'b1;
    return (addr % size_of(op)) != 0;
  endfunction

  function automatic logic [31:0] ld(input logic [2:0] op, input logic [7:0] b0,
                                     input logic [7:0] b1, input logic [7:0] b2,
                                     input logic [7:0] b3);
    case (op)
      DM_W:    return {b3, b2, b1, b0};
      DM_H:    return {{16{b1[7]}}, b1, b0};
      DM_HU:   return {16'h0, b1, b0};
      DM_B:    return {{24{b0[7]}}, b0};
      DM_BU:   return {24'h0, b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic req_t mk(input logic we, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata);
    req_t r;
    r.we = we; r.op = op; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(1));
    r.op    = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(4));
    r.addr  = 32'($urandom_range(63));
    r.wdata = $urandom;
    return r;
  endfunction

  // Data memory: combinational read, write on the clock edge while m_WE is high.
  assign bus.m_rdata = ld(bus.m_op, mem[bus.m_A[7:0]], mem[bus.m_A[7:0] + 8'd1],
                          mem[bus.m_A[7:0] + 8'd2], mem[bus.m_A[7:0] + 8'd3]);

  always @(posedge clk) begin
    if (bus.m_WE) begin
      for (int i = 0; i < size_of(bus.m_op); i++) mem[8'(bus.m_A + 32'(i))] = bus.m_WD[8*i +: 8];
    end
  end

  // Reference model: serves one request at a time, grant by priority plus starvation rule.
  always @(posedge clk) begin
    logic pick;
    cyc++;
    exp_ack = '{1'b0, 1'b0};
    exp_err = '{1'b0, 1'b0};
    exp_rd  = '{32'd0, 32'd0};
    if (reset) begin
      phase = 0; starve = 0; mdl_addr = '0; mdl_wd = '0; mdl_op = DM_W;
      mdl_we = 1'b0; mdl_err = 1'b0;
    end else if (phase == 1) begin
      if (!mdl_we && !mdl_err)
        exp_rd[mdl_owner] = ld(mdl_op, shadow[8'(mdl_addr)], shadow[8'(mdl_addr + 1)],
                               shadow[8'(mdl_addr + 2)], shadow[8'(mdl_addr + 3)]);
      if (mdl_we && !mdl_err)
        for (int i = 0; i < size_of(mdl_op); i++) shadow[8'(mdl_addr + 32'(i))] = mdl_wd[8*i +: 8];
      exp_ack[mdl_owner] = 1'b1;
      exp_err[mdl_owner] = mdl_err;
      phase = 2;
    end else if (phase == 2) begin
      phase = 0;
    end else if (bus.p0_req || bus.p1_req) begin
      pick = bus.p1_req && (!bus.p0_req || starve == LIMIT);
      if (pick || !bus.p1_req) starve = 0;
      else starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
      mdl_owner = pick;
      mdl_we    = pick ? bus.p1_we    : bus.p0_we;
      mdl_op    = pick ? bus.p1_op    : bus.p0_op;
      mdl_addr  = pick ? bus.p1_addr  : bus.p0_addr;
      mdl_wd    = pick ? bus.p1_wdata : bus.p0_wdata;
      mdl_err   = is_bad(mdl_op, mdl_addr);
      grant_log.push_back(int'(pick));
      phase = 1;
    end
  end

  // Compare process plus ack bookkeeping for the agents and the directed checks.
  always @(negedge clk) begin
    check("p0_ack",   32'(bus.p0_ack), 32'(exp_ack[0]));
    check("p0_err",   32'(bus.p0_err), 32'(exp_err[0]));
    check("p0_rdata", bus.p0_rdata,    exp_rd[0]);
    check("p1_ack",   32'(bus.p1_ack), 32'(exp_ack[1]));
    check("p1_err",   32'(bus.p1_err), 32'(exp_err[1]));
    check("p1_rdata", bus.p1_rdata,    exp_rd[1]);
    check("m_WE",     32'(bus.m_WE),   32'(phase == 1 && mdl_we && !mdl_err && !reset));
    check("m_A",      bus.m_A,         mdl_addr);
    check("m_WD",     bus.m_WD,        mdl_wd);
    check("m_op",     32'(bus.m_op),   32'(mdl_op));
    if (bus.m_WE) we_cnt++;
    if (bus.p0_ack) begin
      seen0 = 1'b1; last_rd0 = bus.p0_rdata; last_err0 = bus.p0_err;
      lat0 = cyc - t0; n_ack0++; ack_log.push_back(0);
    end
    if (bus.p1_ack) begin
      seen1 = 1'b1; last_rd1 = bus.p1_rdata; last_err1 = bus.p1_err;
      lat1 = cyc - t1; n_ack1++; ack_log.push_back(1);
    end
    wait0 = (bus.p0_req && !bus.p0_ack) ? wait0 + 1 : 0;
    wait1 = (bus.p1_req && !bus.p1_ack) ? wait1 + 1 : 0;
    if (wait0 > 40) begin
      checks++; errors++; wait0 = 0;
      $display("FAIL p0_wait: no ack after 40 cycles (cycle %0d)", cyc);
    end
    if (wait1 > 40) begin
      checks++; errors++; wait1 = 0;
      $display("FAIL p1_wait: no ack after 40 cycles (cycle %0d)", cyc);
    end
  end

  // Requester agents: drop or replace req on the edge after the ack cycle.
  always @(posedge clk) begin
    req_t r;
    #2;
    if (seen0) begin seen0 = 1'b0; bus.p0_req = 1'b0; end
    if (!bus.p0_req && q0.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
      r = q0.pop_front();
      bus.p0_req = 1'b1; bus.p0_we = r.we; bus.p0_op = r.op;
      bus.p0_addr = r.addr; bus.p0_wdata = r.wdata; t0 = cyc;
    end
    if (seen1) begin seen1 = 1'b0; bus.p1_req = 1'b0; end
    if (!bus.p1_req && q1.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
      r = q1.pop_front();
      bus.p1_req = 1'b1; bus.p1_we = r.we; bus.p1_op = r.op;
      bus.p1_addr = r.addr; bus.p1_wdata = r.wdata; t1 = cyc;
    end
  end

  task automatic drain(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q0.size() > 0 || q1.size() > 0 || bus.p0_req || bus.p1_req || phase != 0) && n < limit);
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL drain: traffic still pending after %0d cycles", limit);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int we_base, n_base0, n_base1;
    int order_cont [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; shadow[i] = 8'h00; end
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_op = DM_W; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_op = DM_W; bus.p1_addr = '0; bus.p1_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_m_A",  bus.m_A, 32'h0);
    check("rst_m_op", 32'(bus.m_op), 32'(DM_W));
    check("rst_ack",  32'({bus.p0_ack, bus.p1_ack}), 32'h0);

    // Word store then load on port 0.
    we_base = we_cnt;
    q0.push_back(mk(1'b1, DM_W, 32'h10, 32'hDEAD_BEEF));
    drain(100);
    check("st_latency",   lat0, 2);
    check("st_we_cycles", we_cnt - we_base, 1);
    check("st_mem",       {mem[19], mem[18], mem[17], mem[16]}, 32'hDEAD_BEEF);
    q0.push_back(mk(1'b0, DM_W, 32'h10, 32'h0));
    drain(100);
    check("ld_latency", lat0, 2);
    check("ld_rdata",   last_rd0, 32'hDEAD_BEEF);
    check("ld_err",     32'(last_err0), 32'h0);

    // Byte store then signed/unsigned byte loads on port 1.
    q1.push_back(mk(1'b1, DM_B, 32'h13, 32'h0000_00A5));
    drain(100);
    q1.push_back(mk(1'b0, DM_B, 32'h13, 32'h0));
    drain(100);
    check("lb_rdata", last_rd1, 32'hFFFF_FFA5);
    check("lb_latency", lat1, 2);
    q1.push_back(mk(1'b0, DM_BU, 32'h13, 32'h0));
    drain(100);
    check("lbu_rdata", last_rd1, 32'h0000_00A5);

    // Rejected accesses: misaligned word/half and an unknown op.
    we_base = we_cnt;
    q0.push_back(mk(1'b1, DM_W, 32'h2, 32'h1111_1111));
    drain(100);
    check("misw_err", 32'(last_err0), 32'h1);
    check("misw_rd",  last_rd0, 32'h0);
    q0.push_back(mk(1'b1, DM_H, 32'h1, 32'h0000_2222));
    drain(100);
    check("mish_err", 32'(last_err0), 32'h1);
    q0.push_back(mk(1'b0, DM_H, 32'h11, 32'h0));
    drain(100);
    check("mish_ld_err", 32'(last_err0), 32'h1);
    check("mish_ld_rd",  last_rd0, 32'h0);
    q0.push_back(mk(1'b0, 3'd7, 32'h10, 32'h0));
    drain(100);
    check("badop_err", 32'(last_err0), 32'h1);
    check("badop_rd",  last_rd0, 32'h0);
    check("err_no_we", we_cnt - we_base, 0);
    check("err_mem_lo", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);
    check("err_mem_hi", {mem[7], mem[6], mem[5], mem[4]}, 32'h0);

    // Reset during the memory cycle of a port-1 store.
    @(posedge clk);
    #1;
    n_base1 = n_ack1; we_base = we_cnt;
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_op = DM_W;
    bus.p1_addr = 32'h80; bus.p1_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(bus.m_WE), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.p1_req = 1'b0;
    @(negedge clk);
    check("rst_p1_ack",   32'(bus.p1_ack), 32'h0);
    check("rst_p1_rdata", bus.p1_rdata, 32'h0);
    check("rst_m_A2",     bus.m_A, 32'h0);
    check("rst_m_WD",     bus.m_WD, 32'h0);
    check("rst_m_op2",    32'(bus.m_op), 32'(DM_W));
    repeat (3) @(negedge clk);
    check("rst_no_ack",   n_ack1 - n_base1, 0);
    check("rst_no_write", we_cnt - we_base, 0);
    check("rst_mem",      {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'h0);
    q1.push_back(mk(1'b1, DM_W, 32'h80, 32'h1234_5678));
    drain(100);
    check("rst_fresh_ack", n_ack1 - n_base1, 1);
    check("rst_fresh_mem", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, 32'h1234_5678);

    // Both requests rise together with no starvation history.
    grant_log.delete(); ack_log.delete();
    q0.push_back(mk(1'b0, DM_W, 32'h10, 32'h0));
    q1.push_back(mk(1'b0, DM_BU, 32'h13, 32'h0));
    drain(100);
    check("same_n",     ack_log.size(), 2);
    check("same_first", ack_log[0], 0);
    check("same_next",  ack_log[1], 1);
    check("same_model", grant_log[1], 1);

    // Both ports requesting back to back: LIMIT grants to p0, then one to p1.
    grant_log.delete(); ack_log.delete();
    for (int i = 0; i < 10; i++) q0.push_back(mk(1'b0, DM_W, 32'(4 * i), 32'h0));
    for (int i = 0; i < 3; i++)  q1.push_back(mk(1'b0, DM_W, 32'(8'h40 + 4 * i), 32'h0));
    drain(300);
    check("cont_n", ack_log.size(), 13);
    for (int i = 0; i < 13; i++) check($sformatf("cont_order%0d", i), ack_log[i], order_cont[i]);
    check("cont_model", grant_log[4], 1);

    // Randomized traffic on both ports with idle gaps.
    gap_pct = 30;
    n_base0 = n_ack0; n_base1 = n_ack1;
    for (int i = 0; i < 150; i++) begin
      q0.push_back(rand_req());
      q1.push_back(rand_req());
    end
    drain(4000);
    check("rand_acks0", n_ack0 - n_base0, 150);
    check("rand_acks1", n_ack1 - n_base1, 150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
